// File: rtl/nds_fifo_wr_arb.sv
// nds_fifo_wr_arb: round-robin burst arbiter sharing one FIFO write port, with full gating and drain/flush handshake.
module nds_fifo_wr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                          w_clk,
   input  logic                          w_reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            data_ack,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   input  logic                          fifo_full,
   input  logic                          fifo_empty_w,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic                          busy
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d, win, cand;
   logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic                 flush_done_q, flush_done_d, found;
   assign gnt          = gnt_q;
   assign flush_done   = flush_done_q;
   assign busy         = state_q != IDLE;
   assign fifo_wr      = (state_q == BURST) & req_valid[owner_q] & ~fifo_full;
   assign data_ack     = gnt_q & {NUM_REQ{fifo_wr}};
   assign fifo_wr_data = fifo_wr ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   // Scan downward so the requester closest at-or-after rr_ptr wins.
   always_comb begin
      win   = rr_ptr_q;
      found = 1'b0;
      cand  = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      flush_done_d = 1'b0;
      case (state_q)
         IDLE:
            if (flush_req) state_d = FLUSH;
            else if (found) begin
               state_d    = BURST;
               gnt_d      = NUM_REQ'(1) << win;
               owner_d    = win;
               beat_cnt_d = req_len[win*LEN_WIDTH +: LEN_WIDTH];
            end
         BURST:
            if (fifo_wr) begin
               if (beat_cnt_q == '0) begin
                  state_d  = IDLE;
                  gnt_d    = '0;
                  rr_ptr_d = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
               end else beat_cnt_d = beat_cnt_q - 1'b1;
            end
         FLUSH:
            if (fifo_empty_w) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge w_clk or negedge w_reset_n) begin
      if (!w_reset_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         flush_done_q <= flush_done_d;
      end
   end
endmodule

// File: tb/tb_nds_fifo_wr_arb.sv
// tb_nds_fifo_wr_arb: directed scenarios for the round-robin FIFO write arbiter.
module tb_nds_fifo_wr_arb;
   logic         w_clk = 1'b0, w_reset_n = 1'b0;
   logic [3:0]   req, req_valid, gnt, data_ack;
   logic [15:0]  req_len;
   logic [127:0] req_data;
   logic         fifo_wr, fifo_full, fifo_empty_w, flush_req, flush_done, busy;
   logic [31:0]  fifo_wr_data;
   logic [7:0]   cnt [4];
   int           checks = 0, errors = 0;

   nds_fifo_wr_arb dut (
      .w_clk(w_clk), .w_reset_n(w_reset_n), .req(req), .req_len(req_len),
      .req_valid(req_valid), .req_data(req_data), .gnt(gnt), .data_ack(data_ack),
      .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
      .fifo_empty_w(fifo_empty_w), .flush_req(flush_req), .flush_done(flush_done),
      .busy(busy)
   );

   always #5 w_clk = ~w_clk;

   // Each requester presents its beat number in the low byte of its data.
   function automatic logic [31:0] dat(int i, int n);
      return {8'hA0 | 8'(i), 16'h0, 8'(n)};
   endfunction

   task automatic refresh();
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = dat(i, int'(cnt[i]));
   endtask

   task automatic step();
      logic [3:0] ack;
      ack = data_ack;
      @(posedge w_clk);
      #1;
      for (int i = 0; i < 4; i++) if (ack[i]) cnt[i] = cnt[i] + 8'd1;
      refresh();
   endtask

   task automatic test_reset();
      req = '0; req_len = '0; req_valid = '0; fifo_full = 0; fifo_empty_w = 0; flush_req = 0;
      for (int i = 0; i < 4; i++) cnt[i] = '0;
      refresh();
      w_reset_n = 0;
      repeat (2) @(posedge w_clk);
      #1;
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (data_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", data_ack); end
      checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", fifo_wr); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (fifo_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", fifo_wr_data); end
      w_reset_n = 1;
   endtask

   task automatic test_round_robin();
      logic [3:0] oh;
      req = 4'hF; req_len = 16'h1111; req_valid = 4'hF;
      #1;
      checks++; if (gnt !== 4'b0 || fifo_wr !== 1'b0) begin errors++; $display("FAIL rr_idle got gnt=%b wr=%b want 0000/0", gnt, fifo_wr); end
      step();
      for (int b = 0; b < 5; b++) begin
         oh = 4'(1 << (b % 4));
         for (int n = 0; n < 2; n++) begin
            #1;
            checks++; if (gnt !== oh) begin errors++; $display("FAIL rr_gnt b%0d n%0d got %b want %b", b, n, gnt, oh); end
            checks++; if (fifo_wr !== 1'b1 || data_ack !== oh) begin errors++; $display("FAIL rr_wr b%0d n%0d got wr=%b ack=%b want 1/%b", b, n, fifo_wr, data_ack, oh); end
            checks++; if (fifo_wr_data !== dat(b % 4, (b / 4) * 2 + n)) begin errors++; $display("FAIL rr_data b%0d n%0d got %h want %h", b, n, fifo_wr_data, dat(b % 4, (b / 4) * 2 + n)); end
            step();
         end
         if (b == 4) req = '0;
         #1;
         checks++; if (gnt !== 4'b0 || fifo_wr !== 1'b0) begin errors++; $display("FAIL rr_bubble b%0d got gnt=%b wr=%b want 0000/0", b, gnt, fifo_wr); end
         step();
      end
   endtask

   task automatic test_valid_toggle();
      int  ecount, nw;
      logic ew;
      ecount = 0; nw = 0;
      req = 4'b0100; req_len = 16'h0300; req_valid = '0;
      #1;
      step();
      for (int k = 0; k < 8; k++) begin
         req = (k == 0) ? 4'b0100 : 4'b0000;
         req_valid = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         ew = (k % 2 == 0) && (k < 7);
         #1;
         checks++; if (fifo_wr !== ew || data_ack !== (ew ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL vt_wr k%0d got wr=%b ack=%b want %b", k, fifo_wr, data_ack, ew); end
         checks++; if (gnt !== ((k < 7) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL vt_gnt k%0d got %b", k, gnt); end
         checks++; if (fifo_wr_data !== (ew ? dat(2, 2 + ecount) : 32'h0)) begin errors++; $display("FAIL vt_data k%0d got %h want %h", k, fifo_wr_data, ew ? dat(2, 2 + ecount) : 32'h0); end
         if (fifo_wr) nw++;
         if (ew) ecount++;
         step();
      end
      checks++; if (nw != 4) begin errors++; $display("FAIL vt_count got %0d want 4", nw); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vt_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_full_stall();
      int  ecount, nw;
      logic ew;
      ecount = 0; nw = 0;
      req = 4'b1000; req_len = 16'h7000; req_valid = 4'b1000; fifo_full = 0;
      #1;
      step();
      req = '0;
      for (int k = 0; k < 12; k++) begin
         fifo_full = (k >= 2 && k <= 4);
         ew = !fifo_full && (k < 11);
         #1;
         checks++; if (fifo_wr !== ew) begin errors++; $display("FAIL fs_wr k%0d got %b want %b full=%b", k, fifo_wr, ew, fifo_full); end
         checks++; if (fifo_wr_data !== (ew ? dat(3, 2 + ecount) : 32'h0)) begin errors++; $display("FAIL fs_data k%0d got %h want %h", k, fifo_wr_data, ew ? dat(3, 2 + ecount) : 32'h0); end
         if (fifo_wr) nw++;
         if (ew) ecount++;
         step();
      end
      fifo_full = 0;
      checks++; if (nw != 8) begin errors++; $display("FAIL fs_count got %0d want 8", nw); end
      checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL fs_end got gnt=%b busy=%b want 0000/0", gnt, busy); end
   endtask

   task automatic test_flush();
      flush_req = 1; req = 4'b0001; req_len = '0; req_valid = 4'b0001; fifo_empty_w = 0;
      #1;
      step();
      flush_req = 0;
      for (int f = 0; f < 6; f++) begin
         fifo_empty_w = (f == 5);
         #1;
         checks++; if (gnt !== 4'b0 || fifo_wr !== 1'b0) begin errors++; $display("FAIL fl_gnt f%0d got gnt=%b wr=%b want 0000/0", f, gnt, fifo_wr); end
         checks++; if (busy !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL fl_state f%0d got busy=%b done=%b want 1/0", f, busy, flush_done); end
         step();
      end
      #1;
      checks++; if (flush_done !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL fl_done got done=%b busy=%b gnt=%b want 1/0/0000", flush_done, busy, gnt); end
      fifo_empty_w = 0;
      step();
      req = '0;
      #1;
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL fl_pulse got %b want 0", flush_done); end
      checks++; if (gnt !== 4'b0001 || fifo_wr !== 1'b1 || fifo_wr_data !== dat(0, 4)) begin errors++; $display("FAIL fl_grant got gnt=%b wr=%b data=%h want 0001/1/%h", gnt, fifo_wr, fifo_wr_data, dat(0, 4)); end
      step();
      #1;
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL fl_after got %b want 0000", gnt); end
   endtask

   task automatic test_reset_mid_burst();
      req = 4'b0010; req_len = 16'h00F0; req_valid = 4'b0010;
      #1;
      step();
      req = '0;
      for (int n = 0; n < 3; n++) begin
         #1;
         checks++; if (gnt !== 4'b0010 || fifo_wr !== 1'b1) begin errors++; $display("FAIL rm_burst n%0d got gnt=%b wr=%b want 0010/1", n, gnt, fifo_wr); end
         step();
      end
      w_reset_n = 0;
      #1;
      checks++; if (gnt !== 4'b0 || fifo_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_abort got gnt=%b wr=%b busy=%b want 0000/0/0", gnt, fifo_wr, busy); end
      step();
      #1;
      checks++; if (gnt !== 4'b0 || fifo_wr !== 1'b0) begin errors++; $display("FAIL rm_held got gnt=%b wr=%b want 0000/0", gnt, fifo_wr); end
      w_reset_n = 1; req = 4'b0011; req_len = '0; req_valid = 4'b0011;
      #1;
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rm_idle got %b want 0000", gnt); end
      step();
      req = '0;
      #1;
      checks++; if (gnt !== 4'b0001 || data_ack !== 4'b0001) begin errors++; $display("FAIL rm_first got gnt=%b ack=%b want 0001/0001", gnt, data_ack); end
      step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_valid_toggle();
      test_full_stall();
      test_flush();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
